gpu_rect_rasterizer: RTL and testbench



---
 rtl/gpu_rect_rasterizer.sv | 162 ++++++++++++++++
 tb/tb_gpu_rect_rasterizer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/gpu_rect_rasterizer.sv
// ============================================================================
// gpu_rect_rasterizer : rectangle fill / sprite blit into the framebuffer,
// one pixel per enabled cycle. Optional macro: GPU_TRANSPARENCY_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

package gpu_pkg;
    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic [10:0] width;
        logic [10:0] height;
        logic [11:0] color;
        logic        mem_en;
        logic [15:0] mem_addr;
        logic        scale;
    } gpu_op_t;
endpackage

module gpu_rect_rasterizer #(
    parameter int HOR_ACTIVE_PIXELS = 640,
    parameter int VER_ACTIVE_PIXELS = 480,
    parameter int COLOR_BITS        = 12,
    parameter int MEM_ADDR_BITS     = 16,
    parameter int FB_ADDR_BITS      = $clog2(HOR_ACTIVE_PIXELS*VER_ACTIVE_PIXELS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ce,
    input  gpu_pkg::gpu_op_t         op,
    input  logic                     op_valid,
    output logic                     op_ready,
    output logic [MEM_ADDR_BITS-1:0] mem_rd_addr,
    input  logic [COLOR_BITS-1:0]    mem_rd_data,
    output logic                     fb_wr_en,
    output logic [FB_ADDR_BITS-1:0]  fb_wr_addr,
    output logic [COLOR_BITS-1:0]    fb_wr_data
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FILL   = 3'd1,
        S_SPRITE = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    gpu_pkg::gpu_op_t        r_op;
    logic [10:0]             r_col;
    logic [10:0]             r_row;
    logic                    r_s_valid;
    logic [FB_ADDR_BITS-1:0] r_s_addr;

    logic                    w_accept;
    logic                    w_zero_area;
    logic                    w_last_col;
    logic                    w_last_px;
    logic [11:0]             w_px;
    logic [11:0]             w_py;
    logic                    w_in_bounds;
    logic [FB_ADDR_BITS-1:0] w_pix_addr;
    logic [11:0]             w_stride;
    logic [10:0]             w_tc;
    logic [10:0]             w_tr;
    logic                    w_transp;

    assign w_accept    = ce && op_valid && (state == S_IDLE);
    assign w_zero_area = (op.width == 11'd0) || (op.height == 11'd0);
    assign w_last_col  = (r_col == r_op.width - 11'd1);
    assign w_last_px   = w_last_col && (r_row == r_op.height - 11'd1);

    // Screen coordinates use 12 bits so x+col never wraps back on screen.
    assign w_px        = {1'b0, r_op.x} + {1'b0, r_col};
    assign w_py        = {1'b0, r_op.y} + {1'b0, r_row};
    assign w_in_bounds = (32'(w_px) < HOR_ACTIVE_PIXELS) && (32'(w_py) < VER_ACTIVE_PIXELS);
    assign w_pix_addr  = FB_ADDR_BITS'(32'(w_py) * 32'(HOR_ACTIVE_PIXELS) + 32'(w_px));

    // Upscaled sprites keep a half-width stride, rounded up for odd widths.
    assign w_stride    = r_op.scale ? (({1'b0, r_op.width} + 12'd1) >> 1) : {1'b0, r_op.width};
    assign w_tc        = r_col >> r_op.scale;
    assign w_tr        = r_row >> r_op.scale;
    assign mem_rd_addr = MEM_ADDR_BITS'(r_op.mem_addr)
                       + MEM_ADDR_BITS'(23'(w_tr) * 23'(w_stride) + 23'(w_tc));

`ifdef GPU_TRANSPARENCY_EN
    assign w_transp = r_op.mem_en && (mem_rd_data == '0);
`else
    assign w_transp = 1'b0;
`endif

    assign op_ready   = (state == S_IDLE);
    assign fb_wr_en   = ce && (((state == S_FILL) && w_in_bounds) || (r_s_valid && !w_transp));
    assign fb_wr_addr = r_op.mem_en ? r_s_addr : w_pix_addr;
    assign fb_wr_data = r_op.mem_en ? mem_rd_data : COLOR_BITS'(r_op.color);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_zero_area)
                        state_nxt = S_DONE;
                    else if (op.mem_en)
                        state_nxt = S_SPRITE;
                    else
                        state_nxt = S_FILL;
                end
            end
            S_FILL:   if (w_last_px) state_nxt = S_DONE;
            S_SPRITE: if (w_last_px) state_nxt = S_DRAIN;
            S_DRAIN:  state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else if (ce)
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op  <= '0;
            r_col <= '0;
            r_row <= '0;
        end else if (ce) begin
            if (w_accept) begin
                r_op  <= op;
                r_col <= '0;
                r_row <= '0;
            end else if ((state == S_FILL) || (state == S_SPRITE)) begin
                if (w_last_col) begin
                    r_col <= '0;
                    r_row <= r_row + 11'd1;
                end else begin
                    r_col <= r_col + 11'd1;
                end
            end
        end
    end

    // Sprite pixels trail their ROM address by one cycle to meet the texel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s_valid <= 1'b0;
            r_s_addr  <= '0;
        end else if (ce) begin
            r_s_valid <= (state == S_SPRITE) && w_in_bounds;
            if (state == S_SPRITE)
                r_s_addr <= w_pix_addr;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_gpu_rect_rasterizer.sv
// ============================================================================
// tb_gpu_rect_rasterizer : randomized self-checking bench for the rasterizer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_gpu_rect_rasterizer;
    import gpu_pkg::*;

    localparam int H  = 640;
    localparam int V  = 480;
    localparam int CB = 12;
    localparam int MB = 16;
    localparam int FB = 19;

    logic          clk = 1'b0;
    logic          rst;
    logic          ce;
    gpu_op_t       op;
    logic          op_valid;
    logic          op_ready;
    logic [MB-1:0] mem_rd_addr;
    logic [CB-1:0] mem_rd_data;
    logic          fb_wr_en;
    logic [FB-1:0] fb_wr_addr;
    logic [CB-1:0] fb_wr_data;

    always #5 clk = ~clk;

    gpu_rect_rasterizer #(
        .HOR_ACTIVE_PIXELS(H),
        .VER_ACTIVE_PIXELS(V),
        .COLOR_BITS(CB),
        .MEM_ADDR_BITS(MB),
        .FB_ADDR_BITS(FB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ce(ce),
        .op(op),
        .op_valid(op_valid),
        .op_ready(op_ready),
        .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data),
        .fb_wr_en(fb_wr_en),
        .fb_wr_addr(fb_wr_addr),
        .fb_wr_data(fb_wr_data)
    );

    // Sprite ROM: one ce-cycle read latency
    logic [CB-1:0] rom [0:65535];
    always @(posedge clk) if (ce) mem_rd_data <= rom[mem_rd_addr];

    bit [31:0] cap_q[$];
    bit [31:0] exp_q[$];
    int        exp_ready;
    int        n_tests = 0;
    int        n_fail  = 0;

    always @(negedge clk) if (fb_wr_en === 1'b1) cap_q.push_back({1'b0, fb_wr_addr, fb_wr_data});

    task automatic check(input string tag, input longint obs, input longint expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic gpu_op_t mk(input int x, input int y, input int w, input int h,
                                   input int color, input bit mem_en, input int maddr, input bit scale);
        gpu_op_t o;
        o.x = 11'(x); o.y = 11'(y); o.width = 11'(w); o.height = 11'(h);
        o.color = 12'(color); o.mem_en = mem_en; o.mem_addr = 16'(maddr); o.scale = scale;
        return o;
    endfunction

    // Expected write list and ready latency straight from the rectangle rules
    function automatic void model(input gpu_op_t o);
        int w, h, s, stride, px, py, ta;
        bit [11:0] d;
        exp_q.delete();
        w = int'(o.width); h = int'(o.height); s = int'(o.scale);
        stride = s ? (w + 1) / 2 : w;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                px = int'(o.x) + c;
                py = int'(o.y) + r;
                if (px < H && py < V) begin
                    ta = (int'(o.mem_addr) + (r >> s) * stride + (c >> s)) % 65536;
                    d  = o.mem_en ? rom[ta] : o.color;
`ifdef GPU_TRANSPARENCY_EN
                    if (o.mem_en && d == 12'd0) continue;
`endif
                    exp_q.push_back({1'b0, 19'(py * H + px), d});
                end
            end
        end
        exp_ready = (w * h == 0) ? 2 : w * h + (o.mem_en ? 3 : 2);
    endfunction

    function automatic longint find_data(input int addr);
        foreach (cap_q[i]) if (int'(cap_q[i][30:12]) == addr) return longint'(cap_q[i][11:0]);
        return -1;
    endfunction

    task automatic run_op(input string tag, input gpu_op_t o, input bit toggle, input bit dbl_pulse);
        int edges, cyc, first_bad, n_min;
        bit rdy, c;
        model(o);
        cap_q.delete();
        @(posedge clk); #1;
        op = o; op_valid = 1'b1; ce = 1'b1;
        @(posedge clk); #1;
        check({tag, ".busy"}, op_ready, 0);
        if (dbl_pulse) begin
            op.x = o.x + 11'd1; op.color = ~o.color; op_valid = 1'b1;
        end else begin
            op_valid = 1'b0;
        end
        edges = 0; cyc = 0; rdy = 1'b0;
        while (!rdy && cyc < 4 * exp_ready + 50) begin
            c  = toggle ? ($urandom_range(0, 2) != 0) : 1'b1;
            ce = c;
            @(posedge clk);
            if (c) edges++;
            cyc++;
            #1;
            op_valid = 1'b0;
            rdy = op_ready;
        end
        check({tag, ".ready"}, rdy ? edges + 1 : -1, exp_ready);
        ce = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check({tag, ".count"}, cap_q.size(), exp_q.size());
        n_min = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
        first_bad = n_min;
        for (int i = n_min - 1; i >= 0; i--) if (cap_q[i] != exp_q[i]) first_bad = i;
        check({tag, ".seq"}, first_bad, n_min);
    endtask

    initial begin
        gpu_op_t o;
        rst = 1'b1; ce = 1'b0; op_valid = 1'b0; op = '0;
        for (int i = 0; i < 65536; i++) rom[i] = 12'(i + 1);
        #1;
        check("rst.ready", op_ready, 1);
        check("rst.wr_en", fb_wr_en, 0);
        check("rst.wr_addr", fb_wr_addr, 0);
        check("rst.wr_data", fb_wr_data, 0);
        check("rst.rd_addr", mem_rd_addr, 0);
        repeat (3) @(posedge clk);
        #1; rst = 1'b0; ce = 1'b1;

        run_op("fill_wide", mk(0, 0, 640, 60, 0, 0, 0, 0), 0, 0);
        if (cap_q.size() > 0) check("fill_wide.first", cap_q[0][30:12], 0);

        o = mk(20, 228, 34, 24, 0, 1, 0, 1);
        run_op("sprite", o, 0, 0);
        check("sprite.px20_228", find_data(228 * H + 20), 1);
        check("sprite.px21_229", find_data(229 * H + 21), 1);
        check("sprite.px22_230", find_data(230 * H + 22), 19);
        run_op("sprite_ce", o, 1, 0);

        run_op("clip", mk(630, 470, 20, 20, 12'h5a5, 0, 0, 0), 0, 0);
        if (cap_q.size() > 0) check("clip.first", cap_q[0][30:12], 470 * H + 630);

        run_op("dbl_pulse", mk(5, 5, 3, 2, 12'h123, 0, 0, 0), 0, 1);
        run_op("zero_w", mk(5, 5, 0, 7, 12'h123, 0, 0, 0), 0, 1);

        // Asynchronous reset in the middle of a fill
        @(posedge clk); #1;
        op = mk(0, 0, 100, 10, 12'h00f, 0, 0, 0); op_valid = 1'b1; ce = 1'b1;
        @(posedge clk); #1; op_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        check("mid_rst.pre_wr_en", fb_wr_en, 1);
        rst = 1'b1;
        #1;
        check("mid_rst.wr_en", fb_wr_en, 0);
        check("mid_rst.ready", op_ready, 1);
        @(posedge clk); #1; rst = 1'b0;
        cap_q.delete();
        repeat (10) @(posedge clk);
        #1;
        check("mid_rst.no_writes", cap_q.size(), 0);

        rom[0] = 12'd0; rom[1] = 12'd7; rom[2] = 12'd8; rom[3] = 12'd9;
        run_op("transp", mk(10, 10, 4, 1, 0, 1, 0, 0), 0, 0);
`ifdef GPU_TRANSPARENCY_EN
        check("transp.writes", cap_q.size(), 3);
`else
        check("transp.writes", cap_q.size(), 4);
`endif

        for (int i = 0; i < 65536; i++) rom[i] = ($urandom_range(0, 3) == 0) ? 12'd0 : 12'($urandom);
        for (int t = 0; t < 12; t++) begin
            o = mk($urandom_range(0, 1) ? $urandom_range(600, 660) : $urandom_range(0, 2047),
                   $urandom_range(0, 1) ? $urandom_range(440, 500) : $urandom_range(0, 2047),
                   $urandom_range(0, 12), $urandom_range(0, 12), $urandom,
                   1'($urandom_range(0, 1)),
                   $urandom_range(0, 1) ? $urandom_range(65500, 65535) : $urandom_range(0, 65535),
                   1'($urandom_range(0, 1)));
            run_op($sformatf("rand%0d", t), o, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
